nd_frame_collector: RTL and testbench

//  Receive-side counterpart of the nd-strobed address generator. Captures one data word per
//  nd=1 cycle into an internal RAM at the supplied address, checks the address sequence
//  (0,1,..,MaxAddress,0,..), declares a frame ready once address MaxAddress is written,

---
 rtl/nd_frame_collector.sv | 155 +++++++++++++++
 tb/tb_nd_frame_collector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nd_frame_collector.sv
// -----------------------------------------------------------------------------
// nd_frame_collector
//
// Receive-side partner of the nd-strobed address generator. Each nd=1 cycle
// stores one word in an internal RAM at the supplied address while the
// address sequence 0,1,..,MaxAddress is checked. Once the last address is
// written the frame is held (READY) and played back in address order under
// i_rd_en (DRAIN), after which the block returns to COLLECT for the next frame.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset        asynchronous, active-high; clears all state
//   i_nd           new-data strobe; i_address / i_data_in valid when 1
//   i_address      write address for this word
//   i_data_in      word to store
//   i_rd_en        readout request; honoured only while a frame is held
//   o_data_out     readout word (holds its last value between reads)
//   o_data_valid   1-cycle strobe qualifying o_data_out
//   o_frame_ready  complete frame held, readout not yet finished
//   o_seq_error    sticky: out-of-order or out-of-range address seen
//   o_overrun      sticky: nd=1 received while a frame was being held
// -----------------------------------------------------------------------------
module nd_frame_collector #(
    parameter int MaxAddress = 20,
    parameter int bitwidth   = 5,
    parameter int DataWidth  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_nd,
    input  logic [bitwidth-1:0]  i_address,
    input  logic [DataWidth-1:0] i_data_in,
    input  logic                 i_rd_en,
    output logic [DataWidth-1:0] o_data_out,
    output logic                 o_data_valid,
    output logic                 o_frame_ready,
    output logic                 o_seq_error,
    output logic                 o_overrun
);

    localparam logic [bitwidth-1:0] LastAddr = bitwidth'(MaxAddress);
    localparam logic [bitwidth-1:0] AddrOne  = bitwidth'(1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        READY   = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [bitwidth-1:0]   r_expected;
    logic [bitwidth-1:0]   r_rdPtr;
    logic [DataWidth-1:0]  r_mem [0:MaxAddress];
    logic [DataWidth-1:0]  r_dataOut;
    logic                  r_dataValid;
    logic                  r_seqError;
    logic                  r_overrun;

    logic                  w_addrInRange;
    logic                  w_write;
    logic                  w_readFire;

    assign w_addrInRange = (i_address <= LastAddr);

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // READY always has r_rdPtr==0, so READY and DRAIN share one read path:
    // the first read of a frame is simply the read at pointer 0.
    always_comb begin
        w_nextState = r_state;
        w_write     = 1'b0;
        w_readFire  = 1'b0;
        case (r_state)
            COLLECT: begin
                if (i_nd && w_addrInRange) begin
                    w_write = 1'b1;
                    if (i_address == LastAddr) begin
                        w_nextState = READY;
                    end
                end
            end
            READY, DRAIN: begin
                if (i_rd_en) begin
                    w_readFire = 1'b1;
                    if (r_rdPtr == LastAddr) begin
                        w_nextState = COLLECT;
                    end else begin
                        w_nextState = DRAIN;
                    end
                end
            end
            default: begin
                w_nextState = COLLECT;
            end
        endcase
    end

    // Frame storage; contents are never read before being written, so no reset
    always_ff @(posedge i_clock) begin
        if (w_write) begin
            r_mem[i_address] <= i_data_in;
        end
    end

    // The expected address resynchronises to whatever in-range address arrived,
    // so a single glitch in the sequence is flagged once rather than forever.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_expected <= '0;
            r_seqError <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_write) begin
                r_expected <= (i_address == LastAddr) ? '0 : (i_address + AddrOne);
            end
            if ((r_state == COLLECT) && i_nd &&
                (!w_addrInRange || (i_address != r_expected))) begin
                r_seqError <= 1'b1;
            end
            if ((r_state != COLLECT) && i_nd) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Readout pointer and registered read port
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rdPtr     <= '0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
        end else begin
            r_dataValid <= w_readFire;
            if (w_readFire) begin
                r_dataOut <= r_mem[r_rdPtr];
                r_rdPtr   <= (r_rdPtr == LastAddr) ? '0 : (r_rdPtr + AddrOne);
            end
        end
    end

    assign o_data_out    = r_dataOut;
    assign o_data_valid  = r_dataValid;
    assign o_frame_ready = (r_state != COLLECT);
    assign o_seq_error   = r_seqError;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_nd_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_nd_frame_collector
//
// Drives directed and random nd / rd_en traffic into nd_frame_collector.
// A frame-level model predicts flags after every edge and pushes every
// expected readout word (with the cycle it must appear on) into a queue;
// an independent monitor pops that queue whenever the DUT strobes data_valid.
// -----------------------------------------------------------------------------
module tb_nd_frame_collector;

    localparam int MaxAddr = 20;
    localparam int AW      = 5;
    localparam int DW      = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          nd    = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] dataIn  = '0;
    logic          rdEn    = 1'b0;
    logic [DW-1:0] dataOut;
    logic          dataValid;
    logic          frameReady;
    logic          seqError;
    logic          overrun;

    nd_frame_collector #(
        .MaxAddress (MaxAddr),
        .bitwidth   (AW),
        .DataWidth  (DW)
    ) dut (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_nd          (nd),
        .i_address     (address),
        .i_data_in     (dataIn),
        .i_rd_en       (rdEn),
        .o_data_out    (dataOut),
        .o_data_valid  (dataValid),
        .o_frame_ready (frameReady),
        .o_seq_error   (seqError),
        .o_overrun     (overrun)
    );

    always #5 clock = ~clock;

    int checks     = 0;
    int errors     = 0;
    int cycleCount = 0;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    typedef struct {
        int data;
        int due;
    } exp_t;

    exp_t expQ[$];
    exp_t monItem;

    // Frame-level reference model
    int   modelMem [0:MaxAddr];
    bit   modelHolding;
    int   modelReadIdx;
    int   modelExpected;
    bit   modelSeqErr;
    bit   modelOverrun;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, required, cycleCount);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            if (dataValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_data_valid", 1, 0);
                end else begin
                    monItem = expQ.pop_front();
                    checkOutput("readout_data", int'(dataOut), monItem.data);
                    checkOutput("readout_latency", cycleCount, monItem.due);
                end
            end else if (expQ.size() > 0 && expQ[0].due <= cycleCount) begin
                checkOutput("missing_data_valid", 0, 1);
                void'(expQ.pop_front());
            end
        end
    end

    task automatic modelReset();
        modelHolding  = 1'b0;
        modelReadIdx  = 0;
        modelExpected = 0;
        modelSeqErr   = 1'b0;
        modelOverrun  = 1'b0;
    endtask

    // Predicts the effect of the coming clock edge on the whole frame
    task automatic modelStep(input bit ndV, input int addrV, input int dataV, input bit rdV);
        exp_t item;
        if (!modelHolding) begin
            if (ndV) begin
                if (addrV > MaxAddr) begin
                    modelSeqErr = 1'b1;
                end else begin
                    if (addrV != modelExpected) modelSeqErr = 1'b1;
                    modelMem[addrV] = dataV;
                    modelExpected   = (addrV == MaxAddr) ? 0 : addrV + 1;
                    if (addrV == MaxAddr) begin
                        modelHolding = 1'b1;
                        modelReadIdx = 0;
                    end
                end
            end
        end else begin
            if (ndV) modelOverrun = 1'b1;
            if (rdV) begin
                item.data = modelMem[modelReadIdx];
                item.due  = cycleCount + 1;
                expQ.push_back(item);
                modelReadIdx++;
                if (modelReadIdx > MaxAddr) modelHolding = 1'b0;
            end
        end
    endtask

    // Called just after a rising edge; applies one cycle of stimulus
    task automatic applyStimulus(input bit ndV, input int addrV, input int dataV, input bit rdV);
        nd      = ndV;
        address = AW'(addrV);
        dataIn  = DW'(dataV);
        rdEn    = rdV;
        modelStep(ndV, addrV, dataV, rdV);
        @(posedge clock);
        #1;
        checkOutput("frame_ready", int'(frameReady), int'(modelHolding));
        checkOutput("seq_error",   int'(seqError),   int'(modelSeqErr));
        checkOutput("overrun",     int'(overrun),    int'(modelOverrun));
    endtask

    // Reset is raised between clock edges and its effect checked before any edge
    task automatic applyReset();
        #2;
        reset = 1'b1;
        nd    = 1'b0;
        rdEn  = 1'b0;
        #1;
        checkOutput("reset_data_valid",  int'(dataValid),  0);
        checkOutput("reset_data_out",    int'(dataOut),    0);
        checkOutput("reset_frame_ready", int'(frameReady), 0);
        checkOutput("reset_seq_error",   int'(seqError),   0);
        checkOutput("reset_overrun",     int'(overrun),    0);
        expQ.delete();
        modelReset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic sendFrame(input int dataBase);
        for (int a = 0; a <= MaxAddr; a++) begin
            applyStimulus(1'b1, a, (a + dataBase) & 8'hFF, 1'b0);
        end
    endtask

    task automatic drainFrame(input bit withGaps);
        int budget = 400;
        while (modelHolding && budget > 0) begin
            applyStimulus(1'b0, 0, 0, withGaps ? 1'($urandom_range(0, 1)) : 1'b1);
            budget--;
        end
        if (modelHolding) checkOutput("drain_timeout", 0, 1);
    endtask

    initial begin
        int seqList[$];
        bit rNd;
        int rAddr;
        modelReset();
        @(posedge clock);
        #1;
        applyReset();

        $display("[TB] test 1: clean frame collection");
        sendFrame(8'h10);

        $display("[TB] test 2: continuous readout");
        drainFrame(1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1);

        $display("[TB] test 3: address skip");
        seqList = {0, 1, 2};
        for (int a = 5; a <= MaxAddr; a++) seqList.push_back(a);
        foreach (seqList[i]) applyStimulus(1'b1, seqList[i], 8'h80 + seqList[i], 1'b0);
        drainFrame(1'b1);

        $display("[TB] test 4: overrun while frame held");
        applyReset();
        sendFrame(8'h10);
        applyStimulus(1'b1, 0, 8'hAA, 1'b0);
        drainFrame(1'b1);

        $display("[TB] test 5: out-of-range address");
        applyReset();
        applyStimulus(1'b1, 25, 8'h55, 1'b0);
        sendFrame(8'h30);
        drainFrame(1'b0);

        $display("[TB] test 6: reset mid-readout");
        applyReset();
        sendFrame(8'h40);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 0, 0, 1'b1);
        applyReset();
        sendFrame(8'h60);
        drainFrame(1'b1);

        $display("[TB] random traffic");
        applyReset();
        for (int i = 0; i < 600; i++) begin
            rNd   = ($urandom_range(0, 3) != 0);
            rAddr = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 31)) : modelExpected;
            applyStimulus(rNd, rAddr, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        drainFrame(1'b0);

        nd   = 1'b0;
        rdEn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
